// File: rtl/dec_rr_arbiter_if.sv
// Handshake bundle between the round-robin arbiter and its requesters/decoder datapath.
interface dec_rr_arbiter_if;
    logic       en;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_vld;
    logic       timeout;

    modport master (
        output en, req, done,
        input  gnt, gnt_idx, gnt_vld, timeout
    );

    modport slave (
        input  en, req, done,
        output gnt, gnt_idx, gnt_vld, timeout
    );
endinterface

// File: rtl/dec_rr_arbiter.sv
// Eight-way round-robin arbiter with registered index and one-hot grant, one dead cycle between grants.
// Define ARB_TIMEOUT_EN to build the HOLD_MAX hold counter and the timeout pulse.
module dec_rr_arbiter #(
    parameter int unsigned HOLD_MAX = 15
) (
    input  logic             clk,
    input  logic             rst,
    dec_rr_arbiter_if.slave  arb
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] gnt_q, gnt_d;
    logic       vld_q, vld_d;

    logic [2:0] win_idx;
    logic       win_vld;
    logic       start;
    logic       soft_exit;
    logic       hold_hit;
    logic       grant_exit;

    // First set request at or after ptr, wrapping modulo 8.
    always_comb begin
        win_idx = ptr_q;
        win_vld = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (!win_vld && arb.req[ptr_q + 3'(i)]) begin
                win_vld = 1'b1;
                win_idx = ptr_q + 3'(i);
            end
        end
    end

    assign start      = arb.en & win_vld;
    assign soft_exit  = arb.done | ~arb.req[idx_q] | ~arb.en;
    assign grant_exit = soft_exit | hold_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            gnt_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            gnt_q   <= gnt_d;
            vld_q   <= vld_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = start ? GRANT : IDLE;
            GRANT:   state_d = grant_exit ? RELEASE : GRANT;
            RELEASE: state_d = start ? GRANT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ptr_d = ptr_q;
        idx_d = idx_q;
        gnt_d = gnt_q;
        unique case (state_q)
            GRANT: begin
                if (grant_exit) begin
                    gnt_d = '0;
                    ptr_d = idx_q + 3'd1;
                end
            end
            default: begin
                gnt_d = '0;
                if (start) begin
                    idx_d = win_idx;
                    gnt_d = 8'd1 << win_idx;
                end
            end
        endcase
        vld_d = |gnt_d;
    end

`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold_q, hold_d;
    logic       timeout_q;

    // Counter is zero on the first GRANT cycle, so HOLD_MAX-1 marks the last allowed cycle.
    always_comb begin
        hold_d = '0;
        if (state_q == GRANT) begin
            hold_d = (hold_q == '1) ? hold_q : hold_q + 8'd1;
        end
    end

    assign hold_hit = ({1'b0, hold_q} + 9'd1) >= 9'(HOLD_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= (state_q == GRANT) & hold_hit & ~soft_exit;
        end
    end

    assign arb.timeout = timeout_q;
`else
    logic [7:0] unused_hold_max;

    assign unused_hold_max = 8'(HOLD_MAX);
    assign hold_hit        = 1'b0;
    assign arb.timeout     = 1'b0;
`endif

    assign arb.gnt     = gnt_q;
    assign arb.gnt_idx = idx_q;
    assign arb.gnt_vld = vld_q;

endmodule
